// File: rtl/adder_op_issuer.sv
// Operand-pair feeder for a sequential adder: queues pairs in a small FIFO,
// issues one at a time with a start pulse and returns sum/overflow/timeout.
module adder_op_issuer #(
   parameter int WIDTH   = 32,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_a,
   input  logic [WIDTH-1:0]         in_b,
   output logic                     adder_start,
   output logic [WIDTH-1:0]         adder_a,
   output logic [WIDTH-1:0]         adder_b,
   input  logic                     adder_ready,
   input  logic [WIDTH-1:0]         adder_res,
   input  logic                     adder_overflow,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_res,
   output logic                     out_overflow,
   output logic                     out_timeout,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic [1:0]               dbg_state
);

   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(TIMEOUT);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
   localparam logic [AW:0]   FULL_LEVEL = (AW + 1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_OUT   = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [WIDTH-1:0]  r_mem_a [DEPTH];
   logic [WIDTH-1:0]  r_mem_b [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [AW:0]       r_count;
   logic [WIDTH-1:0]  r_op_a;
   logic [WIDTH-1:0]  r_op_b;
   logic [WIDTH-1:0]  r_out_res;
   logic              r_out_ovf;
   logic              r_out_to;
   logic              r_seen_low;
   logic [TW-1:0]     r_timer;
   logic              w_push;
   logic              w_pop;
   logic              w_done;
   logic              w_expire;

   // Both ports are valid/ready: a transfer happens on a rising edge where valid
   // and ready are both high; the source holds its payload while valid && !ready.
   assign in_ready = (r_count != FULL_LEVEL);
   assign w_push   = in_valid & in_ready;
   assign w_pop    = (r_state == S_IDLE) && (r_count != '0);

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_a[r_wr_ptr] <= in_a;
         r_mem_b[r_wr_ptr] <= in_b;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   // Completion wins over expiry when both land in the same WAIT cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_done      = 1'b0;
      w_expire    = 1'b0;
      case (r_state)
         S_IDLE:  if (r_count != '0) w_state_nxt = S_ISSUE;
         S_ISSUE: w_state_nxt = S_WAIT;
         S_WAIT: begin
            w_done   = adder_ready & r_seen_low;
            w_expire = ~w_done & (r_timer == TIMER_LAST);
            if (w_done | w_expire) w_state_nxt = S_OUT;
         end
         S_OUT:   if (out_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_op_a     <= '0;
         r_op_b     <= '0;
         r_timer    <= '0;
         r_seen_low <= 1'b0;
         r_out_res  <= '0;
         r_out_ovf  <= 1'b0;
         r_out_to   <= 1'b0;
      end else begin
         if (w_pop) begin
            r_op_a <= r_mem_a[r_rd_ptr];
            r_op_b <= r_mem_b[r_rd_ptr];
         end
         // A ready level carried over from the last operation only counts after a low.
         if (r_state == S_ISSUE) begin
            r_timer    <= '0;
            r_seen_low <= 1'b0;
         end else if (r_state == S_WAIT) begin
            if (r_timer != TIMER_LAST) r_timer <= r_timer + 1'b1;
            if (!adder_ready) r_seen_low <= 1'b1;
         end
         if (w_done) begin
            r_out_res <= adder_res;
            r_out_ovf <= adder_overflow;
            r_out_to  <= 1'b0;
         end else if (w_expire) begin
            r_out_res <= '0;
            r_out_ovf <= 1'b0;
            r_out_to  <= 1'b1;
         end
      end
   end

   assign adder_start  = (r_state == S_ISSUE);
   assign adder_a      = r_op_a;
   assign adder_b      = r_op_b;
   assign out_valid    = (r_state == S_OUT);
   assign out_res      = r_out_res;
   assign out_overflow = r_out_ovf;
   assign out_timeout  = r_out_to;
   assign fifo_level   = r_count;
   assign dbg_state    = r_state;

endmodule

// File: doc/adder_op_issuer.md
Name: adder_op_issuer

Overview:
- Upstream feeder for the sequential adder.
- Buffers operand pairs from a producer in a small FIFO and issues one pair at a time with a one-cycle start pulse.
- Waits for the adder's ready, or gives up after a timeout, then presents the result, overflow and timeout flags on a valid/ready output port.
- Serialises back-to-back requests so the adder never receives a start while it is busy.

Parameters:
- WIDTH, 32, operand and result width.
- DEPTH, 4, operand FIFO entries; power of 2, at least 2.
- TIMEOUT, 64, WAIT-state cycle limit before the operation is abandoned; at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  producer has an operand pair.
- in_ready  out  1  FIFO can accept; equals !full.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- adder_start  out  1  one-cycle start pulse to the adder.
- adder_a  out  WIDTH  operand A to the adder.
- adder_b  out  WIDTH  operand B to the adder.
- adder_ready  in  1  adder done/idle level.
- adder_res  in  WIDTH  adder sum.
- adder_overflow  in  1  adder carry-out.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_res  out  WIDTH  captured sum.
- out_overflow  out  1  captured overflow.
- out_timeout  out  1  operation abandoned.
- fifo_level  out  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst low, asynchronous):
  - FSM goes to IDLE; FIFO is empty (fifo_level=0).
  - All outputs are 0, except in_ready=1.
  - adder_a/adder_b operand registers are 0; seen_low=0; timer=0.
- Reset asserted mid-operation discards the in-flight operation and all queued pairs; no out_valid is produced for them.
- FIFO:
  - Push when in_valid & in_ready.
  - Pop only on the IDLE->ISSUE transition.
  - in_ready is driven from the registered count, so it is 0 when full even if a pop happens in the same cycle.
  - A simultaneous push and pop (when not full) leaves the level unchanged.
  - Read and write pointers wrap modulo DEPTH.
- FSM:
  - IDLE: if fifo_level!=0, pop the head into the adder_a/adder_b registers and go to ISSUE. Otherwise stay.
  - ISSUE (exactly 1 cycle): adder_start=1. Clear timer and seen_low. Go to WAIT.
  - WAIT:
    - adder_a/adder_b are held stable.
    - Timer increments every cycle.
    - seen_low is set when adder_ready=0 is sampled.
    - If adder_ready=1 and seen_low=1: capture out_res=adder_res and out_overflow=adder_overflow, set out_timeout=0, go to OUT.
    - Else if timer==TIMEOUT-1: set out_res=0, out_overflow=0, out_timeout=1, go to OUT.
    - Completion has priority over timeout when both occur in the same cycle.
  - OUT: out_valid=1. out_res, out_overflow and out_timeout are stable until out_ready=1. On the handshake, go to IDLE.
- A ready level left high from the previous operation is ignored until a low is seen. This protects against stale ready.
- Latency:
  - Minimum push-to-start is 2 cycles: push cycle N, IDLE pop N+1, adder_start at N+2.
  - Minimum start-to-out_valid is 3 cycles.
- Throughput: at most one operation in flight. The FIFO keeps accepting pushes while the FSM is busy.
- adder_start is never asserted outside ISSUE.
- Widths: no arithmetic is done on data paths; the timer is clog2(TIMEOUT) bits wide and never wraps.

Test Plan:
1. Single op: push a=5, b=7. Adder drops ready the cycle after start and raises it 3 cycles later with res=12, ovf=0. Required: one adder_start pulse; out_valid with out_res=12, out_overflow=0, out_timeout=0.
2. Overflow plus back-pressure: push a=0xFFFFFFFF, b=1; adder returns res=0, ovf=1; hold out_ready=0 for 5 cycles. Required: out_valid held with out_res=0 and out_overflow=1 stable; the next pop happens only after the handshake.
3. FIFO full: push 5 pairs back-to-back (1+1 … 5+5) with the adder stalled. Required:
   - in_ready=0 once fifo_level=4.
   - The 5th pair is accepted only after the first pop.
   - Results come out in order: 2, 4, 6, 8, 10.
4. Timeout: adder_ready held low forever after start. Required: out_valid after exactly TIMEOUT WAIT cycles, with out_timeout=1, out_res=0, out_overflow=0.
5. Stale ready: adder_ready held 1 through ISSUE and the first WAIT cycles, then 0, then 1 with res=9. Required: no capture before the low is seen; out_res=9.
6. Reset mid-WAIT: with 2 queued pairs, pull rst low for 1 cycle. Required:
   - Immediately: adder_start=0, fifo_level=0, out_valid=0.
   - After reset release: no result is produced.
